alu_input_sequencer: RTL

- Front-end between the Basys3 switches/buttons and the ALU operand/op-code inputs.
- Synchronises and debounces the raw buttons, and keeps a persistent 4-bit op-code that is edited by toggling individual bits with buttons.
- On a debounced execute press, snapshots the switches and op-code and issues one ALU operation over a valid/ready handshake.

---
 rtl/alu_input_sequencer_if.sv | 27 ++
 rtl/alu_input_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_input_sequencer_if.sv
// Valid/ready bus carrying one captured ALU operation (operands plus op-code).
// The master issues the request and the ALU (slave) accepts it.
interface alu_input_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        op_code;
  logic              op_valid;
  logic              op_ready;

  modport master (
    output a,
    output b,
    output op_code,
    output op_valid,
    input  op_ready
  );

  modport slave (
    input  a,
    input  b,
    input  op_code,
    input  op_valid,
    output op_ready
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// Basys3 front-end: synchronises and debounces the buttons, keeps a bit-toggled op-code,
// and issues exactly one captured ALU operation per execute press over valid/ready.
module alu_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DATA_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*DATA_W-1:0]   sw,
  input  logic [3:0]            btn_op,
  input  logic                  btn_exec,
  alu_input_sequencer_if.master alu,
  output logic [3:0]            op_sel,
  output logic                  busy
);
  localparam int NBTN = 5;
  localparam int EXEC = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  logic [NBTN-1:0]   w_btn_raw;
  logic [NBTN-1:0]   r_sync1;
  logic [NBTN-1:0]   r_sync2;
  logic [NBTN-1:0]   r_stable;
  logic [NBTN-1:0]   r_stable_d;
  logic [NBTN-1:0]   w_rise;
  logic [CNT_W-1:0]  r_cnt [NBTN];
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_capture;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_op_code;
  logic [3:0]        r_op_sel;
  logic              r_op_valid;
  logic              r_busy;

  assign w_btn_raw = {btn_exec, btn_op};
  assign w_rise    = r_stable & ~r_stable_d;

  // Two-flop synchroniser, debounce counters and the delayed stable level for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= w_btn_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Live op-code: each debounced op button press inverts its bit, in any state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_sel <= 4'b0000;
    end else begin
      r_op_sel <= r_op_sel ^ w_rise[3:0];
    end
  end

  // Next-state logic; exec rises outside IDLE are ignored
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise[EXEC]) begin
          w_state_nxt = S_ISSUE;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (alu.op_ready) begin
          w_state_nxt = S_WAIT_REL;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT_REL: begin
        if (!r_stable[EXEC]) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_REL;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, operand snapshot and registered handshake/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op_code  <= 4'b0000;
      r_op_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_valid <= (w_state_nxt == S_ISSUE);
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        r_a       <= sw[2*DATA_W-1:DATA_W];
        r_b       <= sw[DATA_W-1:0];
        r_op_code <= r_op_sel;
      end
    end
  end

  assign alu.a        = r_a;
  assign alu.b        = r_b;
  assign alu.op_code  = r_op_code;
  assign alu.op_valid = r_op_valid;
  assign op_sel       = r_op_sel;
  assign busy         = r_busy;
endmodule
